uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver in the UartRx block. Configurable data width, parity mode, stop-bit count, oversample ratio and input synchroniser depth. Adds majority-vote bit sampling, false-start rejection, parity/framing/break/overrun reporting, and a valid/ready output handshake. Sits between the pad-side serial input and the UART FIFO or register front end; `en` is the shared oversample tick from the baud generator.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_param.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_FLUSH
  } rx_state_t;

  function automatic int unsigned cnt_width(input int unsigned oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the serial line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic s
);

  logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] sync_d;

  always_comb begin
    sync_d = sync_q;
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_d[0] = in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SyncStages-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, parity/framing/break
// detection and a valid/ready output register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned Oversample = 16,
  parameter int unsigned DataBits   = 8,
  parameter int unsigned Parity     = 0,
  parameter int unsigned StopBits   = 1,
  parameter int unsigned SyncStages = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in,
  output logic [DataBits-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun
);

  localparam int unsigned CntW = cnt_width(Oversample);
  localparam logic [CntW-1:0] CntTop = CntW'(Oversample - 1);
  localparam logic [CntW-1:0] CntHi  = CntW'(Oversample / 2 + 1);
  localparam logic [CntW-1:0] CntMid = CntW'(Oversample / 2);
  localparam logic [CntW-1:0] CntLo  = CntW'(Oversample / 2 - 1);
  localparam logic [3:0] LastData = 4'(DataBits - 1);
  localparam logic [3:0] LastStop = 4'(StopBits - 1);
  localparam parity_e ParMode = (Parity == 1) ? PAR_EVEN :
                                (Parity == 2) ? PAR_ODD  : PAR_NONE;

  logic s;

  uart_rx_sync #(.SyncStages(SyncStages)) u_sync (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .s    (s)
  );

  rx_state_t           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic [1:0]          smp_q, smp_d;
  logic                s_prev_q, s_prev_d;
  logic                perr_q, perr_d;
  logic                all_zero_q, all_zero_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                break_q, break_d;
  logic                overrun_q, overrun_d;
  logic                vote, at_vote, at_end, done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    smp_d        = smp_q;
    s_prev_d     = s_prev_q;
    perr_d       = perr_q;
    all_zero_d   = all_zero_q;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = 1'b0;
    break_d      = 1'b0;
    overrun_d    = 1'b0;
    done         = 1'b0;
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & s) | (smp_q[1] & s);
    at_vote = (cnt_q == CntLo);
    at_end  = (cnt_q == '0);

    if (en) begin
      s_prev_d = s;
      if (state_q != ST_IDLE && state_q != ST_FLUSH) begin
        cnt_d = at_end ? CntTop : cnt_q - CntW'(1);
        if (cnt_q == CntHi)  smp_d[0] = s;
        if (cnt_q == CntMid) smp_d[1] = s;
      end
      case (state_q)
        ST_IDLE: begin
          if (s_prev_q && !s) begin
            state_d    = ST_START;
            cnt_d      = CntTop;
            bit_idx_d  = '0;
            all_zero_d = 1'b1;
            perr_d     = 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state_d = ST_IDLE;
            cnt_d   = CntTop;
          end else if (at_end) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_vote) begin
            shreg_d = {vote, shreg_q[DataBits-1:1]};
            if (vote) all_zero_d = 1'b0;
          end
          if (at_end) begin
            if (bit_idx_q == LastData) begin
              bit_idx_d = '0;
              state_d   = (ParMode == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (at_vote) begin
            perr_d = (^shreg_q) ^ vote ^ (ParMode == PAR_ODD);
            if (vote) all_zero_d = 1'b0;
          end
          if (at_end) state_d = ST_STOP;
        end
        ST_STOP: begin
          // Completion happens at the vote point so the FSM is back in IDLE
          // before the next start edge of a back-to-back frame.
          if (at_vote) begin
            if (!vote) begin
              state_d = ST_FLUSH;
              cnt_d   = CntTop;
              if (all_zero_q) break_d = 1'b1;
              else            frame_err_d = 1'b1;
            end else begin
              all_zero_d = 1'b0;
              if (bit_idx_q == LastStop) begin
                done    = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = CntTop;
              end
            end
          end else if (at_end) begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
        ST_FLUSH: begin
          if (s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (done) begin
      if (!valid_q || ready) begin
        data_d       = shreg_q;
        parity_err_d = perr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CntTop;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      smp_q        <= '1;
      s_prev_q     <= 1'b1;
      perr_q       <= 1'b0;
      all_zero_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      smp_q        <= smp_d;
      s_prev_q     <= s_prev_d;
      perr_q       <= perr_d;
      all_zero_q   <= all_zero_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7O2 instance, each checked
// every cycle against a tick-indexed frame model.
module tb_uart_rx_param;

  localparam int O  = 16;
  localparam int H  = O / 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, ready;
  logic [1:0] line;
  logic [7:0] data0;
  logic [6:0] data1;
  logic valid0, perr0, fe0, brk0, ovr0;
  logic valid1, perr1, fe1, brk1, ovr1;

  uart_rx_param #(.Oversample(16), .DataBits(8), .Parity(0), .StopBits(1),
                  .SyncStages(2)) dut0 (
    .clk(clk), .reset(reset), .en(en), .in(line[0]), .data(data0),
    .valid(valid0), .ready(ready), .parity_err(perr0), .frame_err(fe0),
    .break_det(brk0), .overrun(ovr0));

  uart_rx_param #(.Oversample(16), .DataBits(7), .Parity(2), .StopBits(2),
                  .SyncStages(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .in(line[1]), .data(data1),
    .valid(valid1), .ready(ready), .parity_err(perr1), .frame_err(fe1),
    .break_det(brk1), .overrun(ovr1));

  int nvec = 0, nerr = 0, cyc = 0;
  bit en_rand = 0, rdy_rand = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int p_db(input int k);  return (k == 0) ? 8 : 7; endfunction
  function automatic int p_par(input int k); return (k == 0) ? 0 : 2; endfunction
  function automatic int p_sb(input int k);  return (k == 0) ? 1 : 2; endfunction
  function automatic bit maj(input bit a, input bit b, input bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Model state: mode 0 idle, 1 inside a frame, 2 waiting for line high.
  int       m_mode[2], m_tk[2];
  bit       m_prev[2], m_allz[2], m_perr[2];
  bit [8:0] m_word[2];
  bit       m_fs[2][256];
  bit [7:0] m_syn[2];
  bit [8:0] e_data[2];
  bit       e_valid[2], e_perr[2], e_fe[2], e_brk[2], e_ovr[2];

  int n_fe[2], n_brk[2], n_ovr[2], n_rise[2], rise_cyc[2];
  bit v_prev[2];

  task automatic check(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[dut%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_tk[k] = 0; m_prev[k] = 1; m_allz[k] = 0; m_perr[k] = 0;
    m_word[k] = '0; m_syn[k] = '1;
    e_data[k] = '0; e_valid[k] = 0; e_perr[k] = 0;
    e_fe[k] = 0; e_brk[k] = 0; e_ovr[k] = 0;
  endtask

  // One clock edge: bit b of a frame is voted on the (O*b+H+1)-th en tick
  // after the edge tick, from the line at that tick and the two before it.
  task automatic model_step(input int k, input bit rst, input bit en_i,
                            input bit line_i, input bit rdy);
    bit s, v, done;
    int b, nd, np, last;
    if (rst) begin
      model_reset(k);
      return;
    end
    s = m_syn[k][SS-1];
    m_syn[k] = {m_syn[k][6:0], line_i};
    e_fe[k] = 0; e_brk[k] = 0; e_ovr[k] = 0;
    done = 0;
    nd = p_db(k);
    np = (p_par(k) != 0) ? 1 : 0;
    last = nd + np + p_sb(k);
    if (en_i) begin
      if (m_mode[k] == 0) begin
        if (m_prev[k] && !s) begin
          m_mode[k] = 1; m_tk[k] = 0; m_allz[k] = 1; m_word[k] = '0; m_perr[k] = 0;
        end
      end else if (m_mode[k] == 1) begin
        m_tk[k]++;
        m_fs[k][m_tk[k]] = s;
        if (m_tk[k] >= H + 1 && (m_tk[k] - (H + 1)) % O == 0) begin
          b = (m_tk[k] - (H + 1)) / O;
          v = maj(m_fs[k][m_tk[k]-2], m_fs[k][m_tk[k]-1], s);
          if (b == 0) begin
            if (v) m_mode[k] = 0;
          end else begin
            if (v) m_allz[k] = 0;
            if (b <= nd) m_word[k][b-1] = v;
            else if (np == 1 && b == nd + 1)
              m_perr[k] = (^m_word[k]) ^ v ^ (p_par(k) == 2);
            else if (!v) begin
              m_mode[k] = 2;
              if (m_allz[k]) e_brk[k] = 1; else e_fe[k] = 1;
            end else if (b == last) begin
              done = 1; m_mode[k] = 0;
            end
          end
        end
      end else if (s) begin
        m_mode[k] = 0;
      end
      m_prev[k] = s;
    end
    if (done) begin
      if (!e_valid[k] || rdy) begin
        e_data[k] = m_word[k]; e_perr[k] = m_perr[k]; e_valid[k] = 1;
      end else begin
        e_ovr[k] = 1;
      end
    end else if (e_valid[k] && rdy) begin
      e_valid[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] ad;
    logic av, ap, af, ab, ao;
    for (int k = 0; k < 2; k++) begin
      if (reset) model_reset(k);
      ad = (k == 0) ? {1'b0, data0} : {2'b00, data1};
      av = (k == 0) ? valid0 : valid1;
      ap = (k == 0) ? perr0 : perr1;
      af = (k == 0) ? fe0 : fe1;
      ab = (k == 0) ? brk0 : brk1;
      ao = (k == 0) ? ovr0 : ovr1;
      check(k, "data", ad, e_data[k]);
      check(k, "valid", av, e_valid[k]);
      check(k, "parity_err", ap, e_perr[k]);
      check(k, "frame_err", af, e_fe[k]);
      check(k, "break_det", ab, e_brk[k]);
      check(k, "overrun", ao, e_ovr[k]);
      if (af === 1'b1) n_fe[k]++;
      if (ab === 1'b1) n_brk[k]++;
      if (ao === 1'b1) n_ovr[k]++;
      if (av === 1'b1 && !v_prev[k]) begin
        n_rise[k]++;
        rise_cyc[k] = cyc;
      end
      v_prev[k] = (av === 1'b1);
      model_step(k, reset, en, line[k], ready);
    end
  end

  // Advance until n en ticks have been applied; called at posedge+1.
  task automatic hold(input int n);
    int c = 0;
    while (c < n) begin
      en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rdy_rand) ready = 1'($urandom_range(0, 1));
      if (en) c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int k, input logic [8:0] d, input bit pbit,
                            input bit stop_v, input int spike);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < p_db(k); i++) bits.push_back(d[i]);
    if (p_par(k) != 0) bits.push_back(pbit);
    for (int i = 0; i < p_sb(k); i++) bits.push_back(stop_v);
    foreach (bits[i]) begin
      line[k] = bits[i];
      if (i == spike) begin
        hold(8); line[k] = ~bits[i]; hold(1); line[k] = bits[i]; hold(7);
      end else begin
        hold(O);
      end
    end
    line[k] = 1'b1;
  endtask

  task automatic rand_frame();
    int k;
    logic [8:0] d;
    bit pb;
    k = $urandom_range(0, 1);
    d = 9'($urandom);
    pb = ~^d[6:0];
    rdy_rand = ($urandom_range(0, 1) == 1);
    if (!rdy_rand) ready = 1'b1;
    case ($urandom_range(0, 7))
      0: begin line[k] = 1'b0; hold($urandom_range(1, 6)); line[k] = 1'b1; hold(30); end
      1: begin send_frame(k, d, pb, 1'b0, -1); hold(20); end
      default: begin
        send_frame(k, d, pb ^ ($urandom_range(0, 3) == 0), 1'b1,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1);
        hold($urandom_range(0, 20));
      end
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int m, r;
    reset = 1'b1; en = 1'b1; ready = 1'b1; line = 2'b11;
    for (int k = 0; k < 2; k++) model_reset(k);
    @(posedge clk); #1;
    hold(3);
    check(0, "reset_valid", valid0, 0);
    check(0, "reset_data", data0, 0);
    check(1, "reset_perr", perr1, 0);
    reset = 1'b0;
    hold(20);

    m = cyc;
    send_frame(0, 9'h0A5, 1'b0, 1'b1, -1);
    hold(20);
    check(0, "t1_valid_latency", rise_cyc[0] - m, 156);
    check(0, "t1_data", data0, 8'hA5);
    check(0, "t1_rises", n_rise[0], 1);

    send_frame(1, 9'h041, 1'b1, 1'b1, -1);
    hold(20);
    check(1, "t2_data_a", data1, 7'h41);
    check(1, "t2_perr_a", perr1, 0);
    send_frame(1, 9'h041, 1'b0, 1'b1, -1);
    hold(20);
    check(1, "t2_data_b", data1, 7'h41);
    check(1, "t2_perr_b", perr1, 1);

    r = n_rise[0];
    line[0] = 1'b0; hold(4); line[0] = 1'b1; hold(40);
    check(0, "t3_glitch_rises", n_rise[0], r);
    check(0, "t3_glitch_flags", n_fe[0] + n_brk[0], 0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, -1);
    hold(20);
    check(0, "t3_data", data0, 8'h3C);

    send_frame(0, 9'h0FF, 1'b0, 1'b1, 4);
    hold(20);
    check(0, "t4_spike_data", data0, 8'hFF);

    r = n_rise[0];
    send_frame(0, 9'h055, 1'b0, 1'b0, -1);
    hold(40);
    check(0, "t5_frame_err_count", n_fe[0], 1);
    check(0, "t5_no_valid", n_rise[0], r);
    line[0] = 1'b0; hold(2 * 10 * O); line[0] = 1'b1; hold(40);
    check(0, "t5_break_count", n_brk[0], 1);
    check(0, "t5_frame_err_after_break", n_fe[0], 1);
    check(0, "t5_break_no_valid", n_rise[0], r);

    ready = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b1, -1);
    send_frame(0, 9'h022, 1'b0, 1'b1, -1);
    hold(20);
    check(0, "t6_data", data0, 8'h11);
    check(0, "t6_valid", valid0, 1);
    check(0, "t6_overrun_count", n_ovr[0], 1);
    ready = 1'b1;
    hold(1);
    check(0, "t6_valid_cleared", valid0, 0);

    line[0] = 1'b0; hold(O); line[0] = 1'b1; hold(30);
    reset = 1'b1;
    #1;
    check(0, "t6_reset_valid", valid0, 0);
    check(0, "t6_reset_data", data0, 0);
    hold(2);
    reset = 1'b0;
    hold(20);
    send_frame(0, 9'h033, 1'b0, 1'b1, -1);
    hold(20);
    check(0, "t6_after_reset_data", data0, 8'h33);

    en_rand = 1'b1;
    for (int i = 0; i < 40; i++) rand_frame();
    rdy_rand = 1'b0;
    ready = 1'b1;
    hold(60);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
